// File: rtl/change_dispense_ctrl.sv
// Change dispense sequencer: converts a cent amount into single-coin eject
// commands, choosing coins greedily from the hoppers that can still supply.
//
// state  | meaning
// IDLE   | waiting for a change request, req_ready high
// SELECT | choose the next coin from remaining amount and hopper status
// ISSUE  | eject command pending until the ejector takes it
// DONE   | one-cycle completion pulse, short valid
module change_dispense_ctrl #(
  parameter int MAX_CENTS = 12775,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_amount,
  input  logic [3:0]       hopper_empty,
  output logic             coin_valid,
  input  logic             coin_ready,
  output logic [1:0]       coin_type,
  output logic [CNT_W-1:0] quarters,
  output logic [CNT_W-1:0] dimes,
  output logic [CNT_W-1:0] nickels,
  output logic [CNT_W-1:0] pennies,
  output logic [31:0]      remaining,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [31:0]      MAX_AMT = 32'(MAX_CENTS);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt [4];
  logic [31:0]      rem;
  logic [1:0]       type_q;
  logic             short_q;
  logic             err_q;

  logic             accept;
  logic             reject;
  logic             start;
  logic             coin_fire;
  logic [3:0]       eligible;
  logic             pick_ok;
  logic [1:0]       pick_type;

  function automatic logic [31:0] coin_value(input logic [1:0] t);
    case (t)
      2'd0:    return 32'd25;
      2'd1:    return 32'd10;
      2'd2:    return 32'd5;
      default: return 32'd1;
    endcase
  endfunction

  // Index order is also value order, so the lowest eligible index is the
  // largest coin that fits.
  always_comb begin
    eligible  = '0;
    pick_type = 2'd3;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = (coin_value(2'(i)) <= rem) && !hopper_empty[i] && (cnt[i] != CNT_SAT);
    end
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) pick_type = 2'(i);
    end
    pick_ok = |eligible;
  end

  assign accept    = req_valid && (state == ST_IDLE);
  assign reject    = accept && (req_amount > MAX_AMT);
  assign start     = accept && !reject;
  assign coin_fire = (state == ST_ISSUE) && coin_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    coin_valid = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (start) state_nxt = ST_SELECT;
      end
      ST_SELECT: begin
        if (rem != 32'd0 && pick_ok) state_nxt = ST_ISSUE;
        else                          state_nxt = ST_DONE;
      end
      ST_ISSUE: begin
        coin_valid = 1'b1;
        if (coin_ready) state_nxt = ST_SELECT;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      type_q  <= '0;
      short_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      err_q <= reject;
      if (start) begin
        rem     <= req_amount;
        short_q <= 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end
      if (state == ST_SELECT && rem != 32'd0) begin
        if (pick_ok) type_q  <= pick_type;
        else         short_q <= 1'b1;
      end
      // value <= rem was guaranteed when type_q was chosen, so no underflow
      if (coin_fire) begin
        rem         <= rem - coin_value(type_q);
        cnt[type_q] <= cnt[type_q] + CNT_W'(1);
      end
    end
  end

  assign coin_type = type_q;
  assign quarters  = cnt[0];
  assign dimes     = cnt[1];
  assign nickels   = cnt[2];
  assign pennies   = cnt[3];
  assign remaining = rem;
  assign short     = short_q;
  assign err       = err_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Self-checking bench for change_dispense_ctrl: directed test-plan cases plus
// randomized requests checked against a greedy-change reference model.
module tb_change_dispense_ctrl;

  localparam int MAX_CENTS = 12775;
  localparam int CNT_W     = 9;
  localparam int SAT       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_amount = '0;
  logic [3:0]       hopper_empty = '0;
  logic             coin_valid;
  logic             coin_ready = 1'b0;
  logic [1:0]       coin_type;
  logic [CNT_W-1:0] quarters, dimes, nickels, pennies;
  logic [31:0]      remaining;
  logic             busy, done, short, err;

  change_dispense_ctrl #(.MAX_CENTS(MAX_CENTS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_amount(req_amount),
    .hopper_empty(hopper_empty),
    .coin_valid(coin_valid), .coin_ready(coin_ready), .coin_type(coin_type),
    .quarters(quarters), .dimes(dimes), .nickels(nickels), .pennies(pennies),
    .remaining(remaining), .busy(busy), .done(done), .short(short), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: amount owed, coins paid, short flag of last request
  int coin_val[4] = '{25, 10, 5, 1};
  int m_rem = 0;
  int m_cnt[4] = '{0, 0, 0, 0};
  bit m_short = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // largest coin that fits, is stocked and has not hit the count limit
  function automatic int model_pick(input int rem, input logic [3:0] he);
    for (int i = 0; i < 4; i++)
      if (coin_val[i] <= rem && !he[i] && m_cnt[i] < SAT) return i;
    return -1;
  endfunction

  task automatic check_hold();
    chk("idle_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_coin_valid", coin_valid, 0);
    chk("hold_remaining", remaining, m_rem);
    chk("hold_quarters", quarters, m_cnt[0]);
    chk("hold_dimes", dimes, m_cnt[1]);
    chk("hold_nickels", nickels, m_cnt[2]);
    chk("hold_pennies", pennies, m_cnt[3]);
    chk("hold_short", short, m_short);
  endtask

  task automatic run_request(input logic [31:0] amt, input logic [3:0] he, input int stall_pct,
                             input int first_stall, input bit noise,
                             input bit change_mid, input logic [3:0] he_mid);
    int  cyc = 0;
    int  stalls = 0;
    int  ncoins = 0;
    int  first_wait = 0;
    int  pend = 0;
    bit  prev_valid = 1'b0;
    bit  seen_done = 1'b0;
    bit  abort = 1'b0;
    @(negedge clk);
    check_hold();
    hopper_empty = he;
    req_amount   = amt;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (amt > 32'(MAX_CENTS)) begin
      @(negedge clk);
      chk("reject_err", err, 1);
      chk("reject_ready", req_ready, 1);
      chk("reject_busy", busy, 0);
      chk("reject_coin_valid", coin_valid, 0);
      @(negedge clk);
      chk("reject_err_clear", err, 0);
      check_hold();
      return;
    end
    m_rem = int'(amt);
    m_cnt = '{0, 0, 0, 0};
    m_short = 1'b0;
    while (!seen_done && !abort && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      chk("busy_ready_err", {29'd0, busy, req_ready, err}, 32'b100);
      if (noise) begin
        req_valid  = 1'($urandom_range(0, 1));
        req_amount = $urandom_range(0, 200);
      end
      if (coin_valid) begin
        if (!prev_valid) begin
          pend = model_pick(m_rem, hopper_empty);
          ncoins++;
          if (pend < 0) begin
            chk("unexpected_coin", coin_valid, 0);
            abort = 1'b1;
          end
        end
        if (!abort) begin
          chk("coin_type", coin_type, pend);
          if (change_mid) hopper_empty = he_mid;
          if (ncoins == 1 && first_wait < first_stall) begin
            coin_ready = 1'b0;
            first_wait++;
          end else begin
            coin_ready = ($urandom_range(0, 99) >= stall_pct);
          end
          if (coin_ready) begin
            m_rem -= coin_val[pend];
            m_cnt[pend]++;
          end else begin
            stalls++;
          end
        end
      end else begin
        coin_ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        seen_done = 1'b1;
        req_valid = 1'b0;
        if (m_rem != 0 && model_pick(m_rem, hopper_empty) >= 0) chk("done_early", done, 0);
        m_short = (m_rem != 0);
        chk("done_cycle", cyc, 2 + 2 * ncoins + stalls);
        chk("done_short", short, m_short);
        chk("done_remaining", remaining, m_rem);
        chk("done_quarters", quarters, m_cnt[0]);
        chk("done_dimes", dimes, m_cnt[1]);
        chk("done_nickels", nickels, m_cnt[2]);
        chk("done_pennies", pennies, m_cnt[3]);
      end
      prev_valid = coin_valid;
    end
    req_valid = 1'b0;
    if (!seen_done) chk("done_timeout", done, 1);
  endtask

  initial begin
    logic [31:0] amt;
    #3;
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_short", short, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_coin_type", coin_type, 0);
    chk("rst_counts", {quarters, dimes, nickels, pennies}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_request(37, 4'b0000, 0, 0, 0, 0, 4'b0000);
    chk("tp37_quarters", quarters, 1);
    chk("tp37_dimes", dimes, 1);
    chk("tp37_pennies", pennies, 2);

    run_request(0, 4'b0000, 0, 0, 0, 0, 4'b0000);
    chk("tp0_counts", {quarters, dimes, nickels, pennies}, 0);

    run_request(40, 4'b0001, 0, 0, 0, 0, 4'b0000);
    chk("tp40_dimes", dimes, 4);
    chk("tp40_quarters", quarters, 0);

    run_request(7, 4'b1100, 0, 0, 0, 0, 4'b0000);
    chk("tp7_short", short, 1);
    chk("tp7_remaining", remaining, 7);

    // quarter hopper empties while the first coin is still pending
    run_request(30, 4'b0000, 0, 5, 0, 1, 4'b0001);
    chk("tp30_quarters", quarters, 1);
    chk("tp30_nickels", nickels, 1);

    run_request(32'(MAX_CENTS + 1), 4'b0000, 0, 0, 0, 0, 4'b0000);
    run_request(32'(MAX_CENTS), 4'b0000, 0, 0, 0, 0, 4'b0000);
    chk("max_quarters", quarters, SAT);

    // pennies only: count saturates at SAT and the rest is short
    run_request(600, 4'b0111, 0, 0, 0, 0, 4'b0000);
    chk("sat_pennies", pennies, SAT);
    chk("sat_remaining", remaining, 600 - SAT);

    for (int i = 0; i < 24; i++) begin
      if (i % 7 == 3)       amt = $urandom_range(MAX_CENTS + 1, MAX_CENTS + 5000);
      else if (i % 12 == 5) amt = $urandom_range(1000, MAX_CENTS);
      else                  amt = $urandom_range(0, 150);
      run_request(amt, 4'($urandom_range(0, 15)), $urandom_range(0, 40), 0,
                  1'($urandom_range(0, 1)), 0, 4'b0000);
    end

    // asynchronous reset while a coin is pending
    @(negedge clk);
    hopper_empty = 4'b0000;
    coin_ready   = 1'b0;
    req_amount   = 30;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 10 && !coin_valid; k++) @(negedge clk);
    chk("rst_mid_pending", coin_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_coin_valid", coin_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_remaining", remaining, 0);
    chk("rst_mid_counts", {quarters, dimes, nickels, pennies}, 0);
    chk("rst_mid_coin_type", coin_type, 0);
    chk("rst_mid_short", short, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_rem = 0;
    m_cnt = '{0, 0, 0, 0};
    m_short = 1'b0;
    run_request(16, 4'b0000, 10, 0, 0, 0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
Sequencing controller that turns a change amount in cents into a stream of single-coin eject commands for the coin hopper mechanism. It accepts one request at a time over a valid/ready handshake. It selects coins greedily (25/10/5/1), skipping any denomination whose hopper is empty or whose count has saturated. It reports per-denomination totals in the same 9-bit format the change datapath uses, plus done/short/error status to the vending FSM.

Parameters:
MAX_CENTS, 12775, largest accepted amount in cents; larger requests are rejected with err.
CNT_W, 9, width of each per-denomination count output.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  change request present.
req_ready  out  1  controller can accept a request (IDLE only).
req_amount  in  32  requested change in cents, unsigned.
hopper_empty  in  4  per-denomination empty flags; bit0 quarter, bit1 dime, bit2 nickel, bit3 penny.
coin_valid  out  1  eject command pending.
coin_ready  in  1  ejector accepted the command.
coin_type  out  2  0 quarter, 1 dime, 2 nickel, 3 penny.
quarters, dimes, nickels, pennies  out  CNT_W each  coins issued for the current/last request.
remaining  out  32  cents still owed.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at end of request.
short  out  1  valid with done: amount could not be fully paid.
err  out  1  one-cycle pulse: request rejected (amount > MAX_CENTS).

Behaviour:
- Reset (async, immediate): state=IDLE; coin_valid, done, short, err, busy=0; counts, remaining, coin_type=0; req_ready=1 after reset release.
- States: IDLE, SELECT, ISSUE, DONE.
- IDLE: req_ready=1. On req_valid & req_ready:
  - if req_amount > MAX_CENTS: err=1 the next cycle, stay IDLE, outputs unchanged.
  - else: remaining<=req_amount, all counts<=0, short<=0, go SELECT.
- SELECT (exactly 1 cycle, hopper_empty sampled only here):
  - remaining==0 -> DONE, short=0.
  - else pick the largest denomination with value<=remaining, hopper not empty, and count<2^CNT_W-1; latch coin_type, go ISSUE.
  - no eligible denomination -> DONE, short=1.
- ISSUE: coin_valid=1; coin_type stable until the handshake.
  - On coin_valid & coin_ready: remaining -= value; matching count += 1; coin_valid drops next cycle; go SELECT.
  - Otherwise hold indefinitely; no timeout.
- DONE: done=1 for one cycle (short valid same cycle); go IDLE.
- Hold: counts, remaining and short stay unchanged until the next accepted request.
- Latency:
  - amount 0: accept edge -> SELECT -> done high 2 cycles after acceptance.
  - each coin costs minimum 2 cycles (SELECT + ISSUE with coin_ready high).
  - 37 cents with free ejector: done on cycle 10 after acceptance.
- Arithmetic: remaining unsigned 32-bit and never underflows (value<=remaining enforced). Counts saturate by exclusion, never wrap.
- Boundaries:
  - hopper_empty changing during ISSUE has no effect on the pending coin.
  - req_valid outside IDLE is ignored (req_ready=0).
  - reset mid-ISSUE clears coin_valid immediately.
  - amount==MAX_CENTS accepted; MAX_CENTS+1 rejected.

Test Plan:
- 37 cents, hoppers full, coin_ready=1 -> coin_type sequence 0,1,3,3; quarters=1 dimes=1 nickels=0 pennies=2; remaining=0; done pulse, short=0.
- 0 cents -> no coin_valid; done high 2 cycles after acceptance; all counts 0.
- 40 cents with hopper_empty=4'b0001 -> four dimes; dimes=4, quarters=0; short=0.
- 7 cents with hopper_empty=4'b1100 -> no coins issued; done with short=1; remaining=7.
- 30 cents, coin_ready held low 5 cycles on the first coin -> coin_valid held with coin_type=0 stable; final quarters=1 nickels=1.
- 12776 cents -> err one cycle, req_ready stays 1, no coins issued. Separately, rst_n low mid-ISSUE -> coin_valid=0 immediately and all outputs at reset values.
